// File: rtl/musa_cycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MUSA core.
// Drives datapath strobes, tracks call depth, and enforces memory-ack timeouts.
module musa_cycle_sequencer #(
    parameter int STACK_DEPTH = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [2:0]                           instr_class,
    input  logic                                 branch_taken,
    input  logic                                 imem_ack,
    input  logic                                 dmem_ack,
    output logic                                 imem_req,
    output logic                                 ir_load,
    output logic                                 rf_read,
    output logic                                 alu_en,
    output logic                                 dmem_req,
    output logic                                 dmem_we,
    output logic                                 rf_write,
    output logic                                 wb_sel_mem,
    output logic                                 pc_write,
    output logic [1:0]                           pc_src,
    output logic                                 stack_push,
    output logic                                 stack_pop,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_depth,
    output logic [2:0]                           state,
    output logic                                 halted,
    output logic                                 fault
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_JUMP   = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_CALL   = 3'd5;
    localparam logic [2:0] C_RET    = 3'd6;
    localparam logic [2:0] C_HALT   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      class_q, class_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [CW-1:0]   wait_q,  wait_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            class_q <= '0;
            depth_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            depth_q <= depth_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        depth_d    = depth_q;
        wait_d     = '0;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        rf_read    = 1'b0;
        alu_en     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_write   = 1'b0;
        wb_sel_mem = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + CW'(1);
                    if (wait_q == CW'(MEM_TIMEOUT - 1)) state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                rf_read = 1'b1;
                class_d = instr_class;
                // Stack over/underflow is caught here so EXEC never issues a bad push/pop.
                if (instr_class == C_HALT)
                    state_d = S_HALT;
                else if (instr_class == C_RET && depth_q == '0)
                    state_d = S_FAULT;
                else if (instr_class == C_CALL && depth_q == DW'(STACK_DEPTH))
                    state_d = S_FAULT;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (class_q)
                    C_ALU:   state_d = S_WB;
                    C_LOAD,
                    C_STORE: state_d = S_MEM;
                    C_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        state_d  = S_FETCH;
                    end
                    C_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'd1 : 2'd0;
                        state_d  = S_FETCH;
                    end
                    C_CALL: begin
                        stack_push = 1'b1;
                        pc_write   = 1'b1;
                        pc_src     = 2'd2;
                        depth_d    = depth_q + DW'(1);
                        state_d    = S_FETCH;
                    end
                    C_RET: begin
                        stack_pop = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = 2'd3;
                        depth_d   = depth_q - DW'(1);
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == C_STORE);
                if (dmem_ack) begin
                    if (class_q == C_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                    if (wait_q == CW'(MEM_TIMEOUT - 1)) state_d = S_FAULT;
                end
            end
            S_WB: begin
                rf_write   = 1'b1;
                wb_sel_mem = (class_q == C_LOAD);
                pc_write   = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    assign state       = state_q;
    assign stack_depth = depth_q;

endmodule

// File: tb/tb_musa_cycle_sequencer.sv
// Scoreboard bench for musa_cycle_sequencer: expected per-cycle output vectors are
// queued as stimulus is driven and compared at the following falling edge.
module tb_musa_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] instr_class = 3'd0;
    logic       branch_taken = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, ir_load, rf_read, alu_en, dmem_req, dmem_we;
    logic       rf_write, wb_sel_mem, pc_write, stack_push, stack_pop;
    logic [1:0] pc_src;
    logic [4:0] stack_depth;
    logic [2:0] state;
    logic       halted, fault;

    musa_cycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_class(instr_class),
        .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_load(ir_load), .rf_read(rf_read), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_write(rf_write),
        .wb_sel_mem(wb_sel_mem), .pc_write(pc_write), .pc_src(pc_src),
        .stack_push(stack_push), .stack_pop(stack_pop), .stack_depth(stack_depth),
        .state(state), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_load, rf_read, alu_en, dmem_req, dmem_we;
        logic       rf_write, wb_sel_mem, pc_write;
        logic [1:0] pc_src;
        logic       push, pop;
        logic [4:0] depth;
        logic       halted, fault;
    } obs_t;

    obs_t obs;
    assign obs = {state, imem_req, ir_load, rf_read, alu_en, dmem_req, dmem_we,
                  rf_write, wb_sel_mem, pc_write, pc_src, stack_push, stack_pop,
                  stack_depth, halted, fault};

    obs_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_depth = 0;
    string tag = "init";

    task automatic chk(input string t, input obs_t got, input obs_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got st=%0d vec=%h, want st=%0d vec=%h",
                     t, got.st, got, want.st, want);
        end
    endtask

    function automatic obs_t base(input logic [2:0] s);
        obs_t e;
        e = '0;
        e.st = s;
        e.depth = 5'(exp_depth);
        return e;
    endfunction

    // Called at posedge+1: drive this cycle's inputs, compare at the falling edge.
    task automatic step(input logic s_i, input logic ia_i, input logic da_i,
                        input logic tk_i, input obs_t e);
        start = s_i;
        imem_ack = ia_i;
        dmem_ack = da_i;
        branch_taken = tk_i;
        exp_q.push_back(e);
        @(negedge clk);
        chk(tag, obs, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        exp_depth = 0;
        #1;
        chk({tag, "/reset"}, obs, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        step(1'b1, 1'b0, 1'b0, 1'b0, base(3'd0));
    endtask

    // Terminal state: start and acks must have no effect.
    task automatic terminal_steps(input logic [2:0] s);
        obs_t e;
        for (int k = 0; k < 3; k++) begin
            e = base(s);
            e.halted = (s == 3'd6);
            e.fault  = (s == 3'd7);
            step(1'b1, 1'b1, 1'b1, 1'b1, e);
        end
    endtask

    // Expands one instruction into its expected cycle trace.
    // iw/dw = ack delay in cycles; 15 or more means the ack never arrives.
    task automatic do_instr(input logic [2:0] c, input logic tk, input int iw, input int dw);
        obs_t e;
        instr_class = c;
        $display("instr class=%0d taken=%0d iwait=%0d dwait=%0d depth=%0d",
                 c, tk, iw, dw, exp_depth);
        for (int k = 0; k < 15; k++) begin
            e = base(3'd1);
            e.imem_req = 1'b1;
            e.ir_load  = (k == iw);
            step(1'b0, k == iw, 1'b1, tk, e);
            if (k == iw) break;
        end
        if (iw >= 15) begin terminal_steps(3'd7); return; end

        e = base(3'd2);
        e.rf_read = 1'b1;
        step(1'b0, 1'b1, 1'b1, tk, e);
        if (c == 3'd7) begin terminal_steps(3'd6); return; end
        if ((c == 3'd6 && exp_depth == 0) || (c == 3'd5 && exp_depth == 16)) begin
            terminal_steps(3'd7);
            return;
        end

        e = base(3'd3);
        e.alu_en = 1'b1;
        case (c)
            3'd3: begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
            3'd4: begin e.pc_write = 1'b1; e.pc_src = tk ? 2'd1 : 2'd0; end
            3'd5: begin e.pc_write = 1'b1; e.pc_src = 2'd2; e.push = 1'b1; end
            3'd6: begin e.pc_write = 1'b1; e.pc_src = 2'd3; e.pop = 1'b1; end
            default: ;
        endcase
        step(1'b0, 1'b1, 1'b1, tk, e);
        if (c == 3'd5) exp_depth++;
        if (c == 3'd6) exp_depth--;
        if (c >= 3'd3) return;

        if (c == 3'd1 || c == 3'd2) begin
            for (int k = 0; k < 15; k++) begin
                e = base(3'd4);
                e.dmem_req = 1'b1;
                e.dmem_we  = (c == 3'd2);
                e.pc_write = (c == 3'd2) && (k == dw);
                step(1'b0, 1'b1, k == dw, tk, e);
                if (k == dw) break;
            end
            if (dw >= 15) begin terminal_steps(3'd7); return; end
            if (c == 3'd2) return;
        end

        e = base(3'd5);
        e.rf_write   = 1'b1;
        e.wb_sel_mem = (c == 3'd1);
        e.pc_write   = 1'b1;
        step(1'b0, 1'b1, 1'b1, tk, e);
    endtask

    initial begin
        obs_t e;
        tag = "por";
        #1;
        chk(tag, obs, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tag = "basic";
        do_start();
        do_instr(3'd0, 1'b0, 0, 0);
        do_instr(3'd1, 1'b0, 0, 3);
        do_instr(3'd2, 1'b0, 1, 0);
        do_instr(3'd4, 1'b1, 0, 0);
        do_instr(3'd4, 1'b0, 0, 0);
        do_instr(3'd3, 1'b0, 0, 0);
        do_instr(3'd0, 1'b0, 2, 0);
        do_instr(3'd2, 1'b0, 0, 5);

        tag = "call_ovf";
        for (int i = 0; i < 16; i++) do_instr(3'd5, 1'b0, 0, 0);
        do_instr(3'd5, 1'b0, 0, 0);
        do_reset();

        tag = "ret_unf";
        do_start();
        do_instr(3'd6, 1'b0, 0, 0);
        do_reset();

        tag = "call_ret";
        do_start();
        do_instr(3'd5, 1'b0, 0, 0);
        do_instr(3'd6, 1'b0, 0, 0);
        do_instr(3'd0, 1'b0, 0, 0);

        tag = "dmem_to";
        do_instr(3'd1, 1'b0, 0, 15);
        do_reset();

        tag = "imem_to";
        do_start();
        do_instr(3'd0, 1'b0, 15, 0);
        do_reset();

        tag = "halt";
        do_start();
        do_instr(3'd0, 1'b0, 0, 0);
        do_instr(3'd7, 1'b0, 0, 0);
        do_reset();

        tag = "mid_mem_rst";
        do_start();
        instr_class = 3'd1;
        e = base(3'd1); e.imem_req = 1'b1; e.ir_load = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, e);
        e = base(3'd2); e.rf_read = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, e);
        e = base(3'd3); e.alu_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, e);
        e = base(3'd4); e.dmem_req = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, e);
        step(1'b0, 1'b0, 1'b0, 1'b0, e);
        do_reset();
        do_start();
        do_instr(3'd0, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
